aes_word_io: RTL and testbench

AES_WORD_IO -- requirements
Module: aes_word_io

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_word_ser.sv | 40 ++++
 rtl/aes_word_io.sv | 109 ++++++++++
 tb/tb_aes_word_io.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared widths, FSM state encoding and word-slicing helper for the AES word I/O wrapper.
package aes_pkg;

    localparam int unsigned AES_BLK_W  = 128;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned AES_NWORDS = 4;
    localparam int unsigned AES_IDX_W  = 2;

    localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(AES_NWORDS - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    // Word 0 is the most significant word of the block.
    function automatic int unsigned word_lsb(input logic [AES_IDX_W-1:0] idx);
        return (AES_NWORDS - 1 - 32'(idx)) * AES_WORD_W;
    endfunction

endpackage

// File: rtl/aes_word_ser.sv
// Holds one 128-bit core result and hands it out as four 32-bit words, MSW first,
// over a valid/ready handshake.
module aes_word_ser
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [AES_BLK_W-1:0]  data,
    input  logic                  rd_ready,
    output logic [AES_WORD_W-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  last
);

    logic [AES_BLK_W-1:0] res;
    logic [AES_IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res      <= '0;
            idx      <= '0;
            rd_valid <= 1'b0;
        end else if (load) begin
            res      <= data;
            idx      <= '0;
            rd_valid <= 1'b1;
        end else if (rd_valid && rd_ready) begin
            // Index wraps back to 0 naturally after the final word.
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
                rd_valid <= 1'b0;
            end
        end
    end

    assign rd_data = res[word_lsb(idx) +: AES_WORD_W];
    assign last    = rd_valid && rd_ready && (idx == LAST_IDX);

endmodule

// File: rtl/aes_word_io.sv
// 32-bit word front end for a 128-bit AES core: assembles key and text words,
// launches the core, and streams the result back out word by word.
module aes_word_io
    import aes_pkg::*;
#(
    parameter bit P_KEEP_KEY = 1'b1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_fWrValid,
    output logic                  o_fWrReady,
    input  logic [AES_WORD_W-1:0] i_WrData,
    input  logic                  i_fWrIsKey,
    input  logic                  i_fEnc,
    output logic [AES_BLK_W-1:0]  o_Key,
    output logic [AES_BLK_W-1:0]  o_Text,
    output logic                  o_fEnc,
    output logic                  o_fStart,
    input  logic [AES_BLK_W-1:0]  i_CoreData,
    input  logic                  i_fCoreDone,
    output logic [AES_WORD_W-1:0] o_RdData,
    output logic                  o_fRdValid,
    input  logic                  i_fRdReady,
    output logic                  o_fBusy,
    output logic                  o_fErr
);

    state_t               state;
    logic [AES_IDX_W-1:0] key_cnt;
    logic [AES_IDX_W-1:0] txt_cnt;
    logic                 key_valid;
    logic                 wr_fire;
    logic                 rd_last;

    assign o_fWrReady = (state == ST_LOAD);
    assign o_fBusy    = (state != ST_LOAD);
    assign wr_fire    = i_fWrValid && o_fWrReady;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state     <= ST_LOAD;
            key_cnt   <= '0;
            txt_cnt   <= '0;
            key_valid <= 1'b0;
            o_Key     <= '0;
            o_Text    <= '0;
            o_fEnc    <= 1'b0;
            o_fStart  <= 1'b0;
            o_fErr    <= 1'b0;
        end else begin
            o_fStart <= 1'b0;
            o_fErr   <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (wr_fire) begin
                        if (i_fWrIsKey) begin
                            // key_valid implies key_cnt==0, so a key word after a
                            // complete key restarts at index 0 and clears key_valid.
                            o_Key[word_lsb(key_cnt) +: AES_WORD_W] <= i_WrData;
                            key_cnt   <= key_cnt + 1'b1;
                            key_valid <= (key_cnt == LAST_IDX);
                            if (txt_cnt != '0) begin
                                txt_cnt <= '0;
                                o_fErr  <= 1'b1;
                            end
                        end else if (!key_valid) begin
                            o_fErr <= 1'b1;
                        end else begin
                            o_Text[word_lsb(txt_cnt) +: AES_WORD_W] <= i_WrData;
                            txt_cnt <= txt_cnt + 1'b1;
                            if (txt_cnt == LAST_IDX) begin
                                o_fEnc   <= i_fEnc;
                                o_fStart <= 1'b1;
                                state    <= ST_START;
                            end
                        end
                    end
                end
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (i_fCoreDone) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd_last) begin
                        state <= ST_LOAD;
                        if (!P_KEEP_KEY) begin
                            key_valid <= 1'b0;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    aes_word_ser u_ser (
        .clk      (i_Clk),
        .rst_n    (i_Rst),
        .load     ((state == ST_WAIT) && i_fCoreDone),
        .data     (i_CoreData),
        .rd_ready (i_fRdReady),
        .rd_data  (o_RdData),
        .rd_valid (o_fRdValid),
        .last     (rd_last)
    );

endmodule

// File: tb/tb_aes_word_io.sv
// Directed bench for aes_word_io: one instance keeps the key across blocks,
// the other invalidates it after each block; both share the same stimulus.
module tb_aes_word_io;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_valid = 1'b0;
    logic [31:0]  wr_data = '0;
    logic         wr_is_key = 1'b0;
    logic         enc = 1'b0;
    logic [127:0] core_data = '0;
    logic         core_done = 1'b0;
    logic         rd_ready = 1'b0;

    logic         a_wr_ready, a_enc, a_start, a_rd_valid, a_busy, a_err;
    logic [127:0] a_key, a_text;
    logic [31:0]  a_rd_data;
    logic         b_wr_ready, b_enc, b_start, b_rd_valid, b_busy, b_err;
    logic [127:0] b_key, b_text;
    logic [31:0]  b_rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int hs;
    logic [31:0] rw [4];

    always #5 clk = ~clk;

    aes_word_io #(.P_KEEP_KEY(1'b1)) dut_keep (
        .i_Clk(clk), .i_Rst(rst), .i_fWrValid(wr_valid), .o_fWrReady(a_wr_ready),
        .i_WrData(wr_data), .i_fWrIsKey(wr_is_key), .i_fEnc(enc),
        .o_Key(a_key), .o_Text(a_text), .o_fEnc(a_enc), .o_fStart(a_start),
        .i_CoreData(core_data), .i_fCoreDone(core_done),
        .o_RdData(a_rd_data), .o_fRdValid(a_rd_valid), .i_fRdReady(rd_ready),
        .o_fBusy(a_busy), .o_fErr(a_err)
    );

    aes_word_io #(.P_KEEP_KEY(1'b0)) dut_drop (
        .i_Clk(clk), .i_Rst(rst), .i_fWrValid(wr_valid), .o_fWrReady(b_wr_ready),
        .i_WrData(wr_data), .i_fWrIsKey(wr_is_key), .i_fEnc(enc),
        .o_Key(b_key), .o_Text(b_text), .o_fEnc(b_enc), .o_fStart(b_start),
        .i_CoreData(core_data), .i_fCoreDone(core_done),
        .o_RdData(b_rd_data), .o_fRdValid(b_rd_valid), .i_fRdReady(rd_ready),
        .o_fBusy(b_busy), .o_fErr(b_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic is_key, input logic [31:0] d, input logic e);
        wr_valid  = 1'b1;
        wr_is_key = is_key;
        wr_data   = d;
        enc       = e;
        tick();
        wr_valid  = 1'b0;
    endtask

    initial begin
        rw[0] = 32'h69c4e0d8;
        rw[1] = 32'h6a7b0430;
        rw[2] = 32'hd8cdb780;
        rw[3] = 32'h70b4c55a;

        // Reset values
        tick();
        tick();
        chk("rst_wr_ready", a_wr_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_start", a_start, 0);
        chk("rst_err", a_err, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_rd_data", a_rd_data, 0);
        chk("rst_key", a_key, 0);
        chk("rst_text", a_text, 0);
        chk("rst_enc", a_enc, 0);
        rst = 1'b1;
        tick();

        // Text before any key is dropped with an error pulse
        wr(0, 32'h11111111, 1);
        chk("early_text_err", a_err, 1);
        chk("early_text_start", a_start, 0);
        tick();
        chk("err_one_cycle", a_err, 0);
        chk("early_text_busy", a_busy, 0);

        // Full key then four text words
        wr(1, 32'h00010203, 0);
        wr(1, 32'h04050607, 0);
        wr(1, 32'h08090a0b, 0);
        wr(1, 32'h0c0d0e0f, 0);
        chk("key_no_err", a_err, 0);
        wr(0, 32'h00112233, 0);
        wr(0, 32'h44556677, 0);
        wr(0, 32'h8899aabb, 0);
        chk("text3_no_start", a_start, 0);
        wr(0, 32'hccddeeff, 1);
        chk("blk1_start", a_start, 1);
        chk("blk1_key", a_key, 128'h000102030405060708090a0b0c0d0e0f);
        chk("blk1_text", a_text, 128'h00112233445566778899aabbccddeeff);
        chk("blk1_enc", a_enc, 1);
        chk("blk1_busy", a_busy, 1);
        chk("blk1_wr_ready", a_wr_ready, 0);

        // Done during START must be ignored
        core_done = 1'b1;
        core_data = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        tick();
        core_done = 1'b0;
        chk("start_single_pulse", a_start, 0);
        chk("start_done_ignored", a_rd_valid, 0);

        core_done = 1'b1;
        core_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tick();
        core_done = 1'b0;
        core_data = '0;
        chk("drain_valid_latency", a_rd_valid, 1);

        // Read out with ready toggling 1,0,1,0...
        hs = 0;
        for (int i = 0; i < 16 && hs < 4; i++) begin
            rd_ready = (i % 2 == 0);
            chk("drain_valid", a_rd_valid, 1);
            chk("drain_word", a_rd_data, rw[hs]);
            chk("drain_no_start", a_start, 0);
            tick();
            if (rd_ready) hs++;
        end
        rd_ready = 1'b0;
        chk("drain_handshakes", hs, 4);
        chk("drain_busy_off", a_busy, 0);
        chk("drain_valid_off", a_rd_valid, 0);
        chk("drain_wr_ready", a_wr_ready, 1);

        // Second block, text only: kept key starts, dropped key errors
        wr(0, 32'hdeadbeef, 0);
        chk("drop_err0", b_err, 1);
        chk("keep_no_err0", a_err, 0);
        wr(0, 32'hcafef00d, 0);
        chk("drop_err1", b_err, 1);
        wr(0, 32'h01234567, 0);
        chk("drop_err2", b_err, 1);
        wr(0, 32'h89abcdef, 0);
        chk("drop_err3", b_err, 1);
        chk("drop_no_start", b_start, 0);
        chk("drop_busy", b_busy, 0);
        chk("keep_start", a_start, 1);
        chk("keep_same_key", a_key, 128'h000102030405060708090a0b0c0d0e0f);
        chk("keep_text", a_text, 128'hdeadbeefcafef00d0123456789abcdef);
        chk("keep_enc", a_enc, 0);
        tick();
        core_done = 1'b1;
        core_data = 128'h0123456789abcdeffedcba9876543210;
        tick();
        core_done = 1'b0;
        rd_ready  = 1'b1;
        chk("blk2_word0", a_rd_data, 32'h01234567);
        for (int i = 0; i < 8 && a_rd_valid; i++) tick();
        rd_ready = 1'b0;
        chk("blk2_busy_off", a_busy, 0);

        // Partial text discarded by a key word
        wr(0, 32'h55555555, 0);
        wr(0, 32'h66666666, 0);
        chk("partial_no_err", a_err, 0);
        wr(1, 32'h10111213, 0);
        chk("partial_key_err", a_err, 1);
        wr(1, 32'h14151617, 0);
        chk("rekey_no_err", a_err, 0);
        wr(1, 32'h18191a1b, 0);
        wr(1, 32'h1c1d1e1f, 0);
        wr(0, 32'ha0a1a2a3, 0);
        wr(0, 32'hb0b1b2b3, 0);
        chk("fresh2_no_start", a_start, 0);
        wr(0, 32'hc0c1c2c3, 0);
        chk("fresh3_no_start", a_start, 0);
        wr(0, 32'hd0d1d2d3, 1);
        chk("fresh4_start", a_start, 1);
        chk("fresh_key", a_key, 128'h101112131415161718191a1b1c1d1e1f);
        chk("fresh_text", a_text, 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3);
        tick();
        chk("wait_busy", a_busy, 1);

        // Reset in WAIT aborts; late done is ignored and the key is gone
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", a_busy, 0);
        chk("abort_key", a_key, 0);
        chk("abort_text", a_text, 0);
        core_done = 1'b1;
        core_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tick();
        core_done = 1'b0;
        chk("abort_no_valid", a_rd_valid, 0);
        chk("abort_rd_data", a_rd_data, 0);
        chk("abort_still_idle", a_busy, 0);
        wr(0, 32'h77777777, 0);
        chk("abort_key_invalid", a_err, 1);
        chk("abort_no_start", a_start, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
